// File: rtl/piton_sd_blk_xfer_ctrl.sv
// rtl/piton_sd_blk_xfer_ctrl.sv - multi-block SD read/write sequencer driving the SD controller over Wishbone
// Build option: define PITON_SD_RETRY_EN to reissue a failed block up to MAX_RETRY more times.
module piton_sd_blk_xfer_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16,
  parameter int TMO_W     = 24,
  parameter int MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr_sd,
  input  logic [ADDR_W-1:0] req_addr_dma,
  input  logic [CNT_W-1:0]  req_blkcnt,
  input  logic              req_wr,
  input  logic              req_val,
  output logic              req_rdy,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic              resp_ok,
  output logic              resp_tmo,
  output logic [CNT_W-1:0]  resp_done,
  output logic [7:0]        wb_adr_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i,
  input  logic              sd_int_cmd,
  input  logic              sd_int_data,
  output logic [3:0]        state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_DMA, S_CMD, S_WAIT_CLR, S_ARG, S_WAIT_CMD, S_RD_CMD_ISR,
    S_RD_RESP0, S_WAIT_DAT, S_RD_DAT_ISR, S_CLR_CMD, S_CLR_DAT, S_RESP
  } state_e;

  // SD controller register map and interrupt status bits
  localparam logic [7:0] REG_ARG      = 8'h00;
  localparam logic [7:0] REG_CMD      = 8'h04;
  localparam logic [7:0] REG_RESP0    = 8'h08;
  localparam logic [7:0] REG_CMD_ISR  = 8'h34;
  localparam logic [7:0] REG_DATA_ISR = 8'h3c;
  localparam logic [7:0] REG_DMA      = 8'h60;
  localparam int         INT_CMD_CC   = 0;
  localparam int         INT_DATA_CC  = 0;
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  sd_q, sd_d, dma_q, dma_d;
  logic [CNT_W-1:0]   left_q, left_d, done_q, done_d;
  logic               wr_q, wr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               fail_q, fail_d;   // current attempt failed
  logic               tfl_q, tfl_d;     // that failure was a timeout
  logic               ok_q, ok_d, rtmo_q, rtmo_d, rval_q, rval_d;
  logic               stb_q, stb_d, we_q, we_d;
  logic [7:0]         adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic               bus_ack, waiting, resp0_ok;
  logic               unused_dat;
`ifdef PITON_SD_RETRY_EN
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  logic [RTY_W-1:0]   rty_q, rty_d;
`else
  localparam int unused_max_retry = MAX_RETRY;
`endif

  assign bus_ack    = stb_q && wb_ack_i;
  assign resp0_ok   = (wb_dat_i[31:19] == 13'd0) && (wb_dat_i[16:13] == 4'd0);
  assign unused_dat = ^{wb_dat_i[18:17], wb_dat_i[12:1]};

  assign req_rdy   = (state_q == S_IDLE);
  assign resp_val  = rval_q;
  assign resp_ok   = ok_q;
  assign resp_tmo  = rtmo_q;
  assign resp_done = done_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = stb_q;
  assign wb_sel_o  = 4'hf;
  assign state_o   = state_q;

  // Sequencing, per-block bookkeeping and the next bus request
  always_comb begin
    state_d = state_q; sd_d = sd_q; dma_d = dma_q; left_d = left_q; done_d = done_q;
    wr_d = wr_q; tmo_d = tmo_q; fail_d = fail_q; tfl_d = tfl_q;
    ok_d = ok_q; rtmo_d = rtmo_q; waiting = 1'b0;
`ifdef PITON_SD_RETRY_EN
    rty_d = rty_q;
`endif
    case (state_q)
      S_IDLE: if (req_val) begin
        sd_d = req_addr_sd; dma_d = req_addr_dma; left_d = req_blkcnt; wr_d = req_wr;
        done_d = '0; fail_d = 1'b0; tfl_d = 1'b0; rtmo_d = 1'b0;
`ifdef PITON_SD_RETRY_EN
        rty_d = '0;
`endif
        ok_d    = (req_blkcnt == '0);
        state_d = (req_blkcnt == '0) ? S_RESP : S_DMA;
      end
      S_DMA:        if (bus_ack) state_d = S_CMD;
      S_CMD:        if (bus_ack) state_d = S_WAIT_CLR;
      S_WAIT_CLR:   if (!sd_int_cmd && !sd_int_data) state_d = S_ARG; else waiting = 1'b1;
      S_ARG:        if (bus_ack) state_d = S_WAIT_CMD;
      S_WAIT_CMD:   if (sd_int_cmd) state_d = S_RD_CMD_ISR; else waiting = 1'b1;
      S_RD_CMD_ISR: if (bus_ack) begin
        fail_d  = !wb_dat_i[INT_CMD_CC];
        state_d = wb_dat_i[INT_CMD_CC] ? S_RD_RESP0 : S_CLR_CMD;
      end
      S_RD_RESP0:   if (bus_ack) begin
        fail_d  = !resp0_ok;
        state_d = resp0_ok ? S_WAIT_DAT : S_CLR_CMD;
      end
      S_WAIT_DAT:   if (sd_int_data) state_d = S_RD_DAT_ISR; else waiting = 1'b1;
      S_RD_DAT_ISR: if (bus_ack) begin
        fail_d  = !wb_dat_i[INT_DATA_CC];
        state_d = S_CLR_CMD;
      end
      S_CLR_CMD:    if (bus_ack) state_d = S_CLR_DAT;
      S_CLR_DAT:    if (bus_ack) begin
        if (!fail_q) begin
          done_d = done_q + CNT_W'(1);
          left_d = left_q - CNT_W'(1);
          sd_d   = sd_q + ADDR_W'(1);
          dma_d  = dma_q + ADDR_W'(512);
`ifdef PITON_SD_RETRY_EN
          rty_d  = '0;
`endif
          ok_d    = (left_d == '0);
          state_d = (left_d == '0) ? S_RESP : S_DMA;
        end else begin
`ifdef PITON_SD_RETRY_EN
          if (int'(rty_q) < MAX_RETRY) begin
            rty_d = rty_q + RTY_W'(1); fail_d = 1'b0; tfl_d = 1'b0; state_d = S_DMA;
          end else begin
            ok_d = 1'b0; rtmo_d = tfl_q; state_d = S_RESP;
          end
`else
          ok_d = 1'b0; rtmo_d = tfl_q; state_d = S_RESP;
`endif
        end
      end
      S_RESP:       if (resp_rdy) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    // A stalled wait counts toward its timeout; hitting the ceiling fails the block
    if (waiting) begin
      tmo_d = tmo_q + TMO_W'(1);
      if (tmo_d == TMO_MAX) begin
        fail_d = 1'b1; tfl_d = 1'b1; state_d = S_CLR_CMD;
      end
    end
    if (state_d != state_q && state_d inside {S_WAIT_CLR, S_WAIT_CMD, S_WAIT_DAT})
      tmo_d = '0;

    // Bus outputs are registered copies of what the next state needs
    rval_d = (state_d == S_RESP);
    stb_d = 1'b1; we_d = 1'b1; adr_d = 8'h00; dat_d = 32'h0;
    case (state_d)
      S_DMA:        begin adr_d = REG_DMA; dat_d = 32'(dma_d); end
      S_CMD:        begin
        adr_d = REG_CMD;
        dat_d = {18'b0, wr_d ? 6'd24 : 6'd17, 1'b0, wr_d ? 2'h2 : 2'h1, 3'b110, 2'h1};
      end
      S_ARG:        begin adr_d = REG_ARG; dat_d = 32'(sd_d); end
      S_RD_CMD_ISR: begin adr_d = REG_CMD_ISR;  we_d = 1'b0; end
      S_RD_RESP0:   begin adr_d = REG_RESP0;    we_d = 1'b0; end
      S_RD_DAT_ISR: begin adr_d = REG_DATA_ISR; we_d = 1'b0; end
      S_CLR_CMD:    adr_d = REG_CMD_ISR;
      S_CLR_DAT:    adr_d = REG_DATA_ISR;
      default:      begin stb_d = 1'b0; we_d = 1'b0; end
    endcase
  end

  // State and datapath registers; reset abandons any request in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; sd_q <= '0; dma_q <= '0; left_q <= '0; done_q <= '0;
      wr_q <= 1'b0; tmo_q <= '0; fail_q <= 1'b0; tfl_q <= 1'b0;
      ok_q <= 1'b0; rtmo_q <= 1'b0; rval_q <= 1'b0;
      stb_q <= 1'b0; we_q <= 1'b0; adr_q <= 8'h00; dat_q <= 32'h0;
`ifdef PITON_SD_RETRY_EN
      rty_q <= '0;
`endif
    end else begin
      state_q <= state_d; sd_q <= sd_d; dma_q <= dma_d; left_q <= left_d; done_q <= done_d;
      wr_q <= wr_d; tmo_q <= tmo_d; fail_q <= fail_d; tfl_q <= tfl_d;
      ok_q <= ok_d; rtmo_q <= rtmo_d; rval_q <= rval_d;
      stb_q <= stb_d; we_q <= we_d; adr_q <= adr_d; dat_q <= dat_d;
`ifdef PITON_SD_RETRY_EN
      rty_q <= rty_d;
`endif
    end
  end

endmodule

// File: tb/tb_piton_sd_blk_xfer_ctrl.sv
// tb/tb_piton_sd_blk_xfer_ctrl.sv - scoreboard bench for piton_sd_blk_xfer_ctrl with an SD controller model
module tb_piton_sd_blk_xfer_ctrl;
  localparam int ADDR_W = 32, CNT_W = 16, TMO_W = 4, MAX_RETRY = 2;
  localparam int TMO_LIMIT = (1 << TMO_W) - 1;
  localparam int OC_OK = 0, OC_CMD_NOCC = 1, OC_RESP_ERR = 2, OC_DAT_NOCC = 3, OC_DAT_TMO = 4, OC_CMD_TMO = 5;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_WAIT_CMD = 4'd5, ST_WAIT_DAT = 4'd8;
`ifdef PITON_SD_RETRY_EN
  localparam int RETRIES = MAX_RETRY;
`else
  localparam int RETRIES = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] req_addr_sd, req_addr_dma;
  logic [CNT_W-1:0]  req_blkcnt, resp_done;
  logic req_wr, req_val, req_rdy, resp_val, resp_rdy, resp_ok, resp_tmo;
  logic [7:0] wb_adr_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, sd_int_cmd, sd_int_data;
  logic [3:0] wb_sel_o, state_o;

  typedef struct packed { logic [7:0] adr; logic [31:0] dat; } wr_t;
  typedef struct packed { logic ok; logic tmo; logic [CNT_W-1:0] done; } rsp_t;
  wr_t  exp_wr_q[$];
  rsp_t exp_rsp_q[$];
  int   outcome_q[$];
  int   cur_oc = OC_OK;
  int   errors = 0, checks = 0;
  int   acks = 0, dma_writes = 0, last_wait_dat = 0;
  bit   hold_rdy_low = 0;

  piton_sd_blk_xfer_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TMO_W(TMO_W), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .req_addr_sd(req_addr_sd), .req_addr_dma(req_addr_dma),
    .req_blkcnt(req_blkcnt), .req_wr(req_wr), .req_val(req_val), .req_rdy(req_rdy),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_ok(resp_ok), .resp_tmo(resp_tmo),
    .resp_done(resp_done), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .sd_int_cmd(sd_int_cmd), .sd_int_data(sd_int_data), .state_o(state_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: bus writes and the single response implied by a request and attempt outcomes
  task automatic model_request(input logic [31:0] sd, input logic [31:0] dma, input int cnt,
                               input bit wr, input int ocs[$]);
    int k = 0, done = 0, tries, oc;
    bit failed = 0, tmo = 0, blk_over;
    logic [31:0] cw;
    cw = 32'((wr ? 24 : 17) << 8) | 32'((wr ? 2 : 1) << 5) | 32'h19;
    for (int b = 0; b < cnt && !failed; b++) begin
      tries = 0;
      blk_over = 0;
      while (!blk_over) begin
        oc = (k < ocs.size()) ? ocs[k] : OC_OK;
        k++;
        exp_wr_q.push_back({8'h60, dma});
        exp_wr_q.push_back({8'h04, cw});
        exp_wr_q.push_back({8'h00, sd});
        exp_wr_q.push_back({8'h34, 32'h0});
        exp_wr_q.push_back({8'h3c, 32'h0});
        if (oc == OC_OK) begin
          done++; sd = sd + 1; dma = dma + 512; blk_over = 1;
        end else if (tries < RETRIES) begin
          tries++;
        end else begin
          failed = 1; tmo = (oc == OC_DAT_TMO || oc == OC_CMD_TMO); blk_over = 1;
        end
      end
    end
    exp_rsp_q.push_back({!failed, tmo, CNT_W'(done)});
  endtask

  // SD controller / Wishbone slave model; also checks every write against the scoreboard
  initial begin
    int wait_n = 0, cmd_cnt = -1, dat_cnt = -1, p;
    logic [31:0] rv;
    wr_t e;
    wb_ack_i = 0; wb_dat_i = 0; sd_int_cmd = 0; sd_int_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wb_ack_i = 0; sd_int_cmd = 0; sd_int_data = 0; cmd_cnt = -1; dat_cnt = -1; wait_n = 0;
      end else begin
        if (cmd_cnt > 0) begin cmd_cnt--; if (cmd_cnt == 0) begin sd_int_cmd = 1; cmd_cnt = -1; end end
        if (dat_cnt > 0) begin dat_cnt--; if (dat_cnt == 0) begin sd_int_data = 1; dat_cnt = -1; end end
        if (wb_ack_i) wb_ack_i = 0;
        else if (wb_cyc_o && wb_stb_o) begin
          if (wait_n > 0) wait_n--;
          else begin
            wait_n = $urandom_range(0, 2);
            wb_ack_i = 1;
            acks++;
            if (wb_we_o) begin
              chk("wr_sel", 32'(wb_sel_o), 32'hf);
              if (exp_wr_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL unexpected_write: adr 0x%0h dat 0x%0h, none expected", wb_adr_o, wb_dat_o);
              end else begin
                e = exp_wr_q.pop_front();
                chk("wr_adr", 32'(wb_adr_o), 32'(e.adr));
                chk("wr_dat", wb_dat_o, e.dat);
              end
              case (wb_adr_o)
                8'h60: begin cur_oc = (outcome_q.size() != 0) ? outcome_q.pop_front() : OC_OK; dma_writes++; end
                8'h00: if (cur_oc != OC_CMD_TMO) cmd_cnt = $urandom_range(1, 4);
                8'h34: sd_int_cmd = 0;
                8'h3c: sd_int_data = 0;
                default: ;
              endcase
            end else begin
              case (wb_adr_o)
                8'h34: rv = (cur_oc == OC_CMD_NOCC) ? ($urandom & ~32'd1) : ($urandom | 32'd1);
                8'h08: begin
                  rv = $urandom & 32'h0006_1fff;
                  if (cur_oc == OC_RESP_ERR) begin
                    p = $urandom_range(0, 16);
                    rv = rv | (32'd1 << (p < 4 ? 13 + p : 15 + p));
                  end else if (cur_oc != OC_DAT_TMO) dat_cnt = $urandom_range(1, 4);
                end
                8'h3c: rv = (cur_oc == OC_DAT_NOCC) ? ($urandom & ~32'd1) : ($urandom | 32'd1);
                default: rv = $urandom;
              endcase
              wb_dat_i = rv;
            end
          end
        end
      end
    end
  end

  // Response monitor; resp_rdy is chosen first so the check sees what the DUT will sample
  initial begin
    rsp_t e;
    resp_rdy = 0;
    forever begin
      @(negedge clk);
      resp_rdy = hold_rdy_low ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (!rst && resp_val && resp_rdy) begin
        if (exp_rsp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_response: ok %0b done %0d, none expected", resp_ok, resp_done);
        end else begin
          e = exp_rsp_q.pop_front();
          chk("resp_ok", 32'(resp_ok), 32'(e.ok));
          chk("resp_tmo", 32'(resp_tmo), 32'(e.tmo));
          chk("resp_done", 32'(resp_done), 32'(e.done));
        end
      end
    end
  end

  // Length of the most recent stay in WAIT_DAT
  initial begin
    int run = 0;
    forever begin
      @(negedge clk);
      if (state_o == ST_WAIT_DAT) run++;
      else if (run != 0) begin last_wait_dat = run; run = 0; end
    end
  end

  task automatic issue_req(input logic [31:0] sd, input logic [31:0] dma, input int cnt,
                           input bit wr, input int ocs[$]);
    int n = 0;
    outcome_q = ocs;
    model_request(sd, dma, cnt, wr, ocs);
    while (!req_rdy && n < 500) begin @(negedge clk); n++; end
    chk("req_rdy_before_issue", 32'(req_rdy), 32'd1);
    req_addr_sd = sd; req_addr_dma = dma; req_blkcnt = CNT_W'(cnt); req_wr = wr; req_val = 1;
    @(negedge clk);
    req_val = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_rsp_q.size() != 0 || !req_rdy) && n < 3000) begin @(negedge clk); n++; end
    chk("resp_drained", 32'(exp_rsp_q.size()), 32'd0);
    chk("writes_drained", 32'(exp_wr_q.size()), 32'd0);
    exp_rsp_q.delete(); exp_wr_q.delete();
  endtask

  initial begin
    int q[$];
    int base, n, hi, cnt;
    rst = 1; req_val = 0; req_wr = 0; req_addr_sd = 0; req_addr_dma = 0; req_blkcnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_o), 32'(ST_IDLE));
    chk("rst_req_rdy", 32'(req_rdy), 32'd1);
    chk("rst_resp_val", 32'(resp_val), 32'd0);
    chk("rst_stb_cyc_we", 32'({wb_stb_o, wb_cyc_o, wb_we_o}), 32'd0);
    chk("rst_adr", 32'(wb_adr_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_resp_fields", 32'({resp_ok, resp_tmo, resp_done}), 32'd0);
    rst = 0;

    q = {OC_OK, OC_OK, OC_OK};
    issue_req(32'h100, 32'h8000, 3, 0, q); drain();

    q = {OC_RESP_ERR, OC_RESP_ERR, OC_RESP_ERR};
    issue_req($urandom, $urandom, 1, 1, q); drain();

    q = {OC_DAT_TMO, OC_DAT_TMO, OC_DAT_TMO};
    issue_req($urandom, $urandom, 1, 0, q); drain();
    chk("wait_dat_timeout_cycles", 32'(last_wait_dat), 32'(TMO_LIMIT));

    q = {OC_DAT_NOCC, OC_OK};
    issue_req(32'h40, 32'h1000, 1, 1, q); drain();

    q = {OC_CMD_TMO, OC_CMD_NOCC, OC_CMD_NOCC};
    issue_req(32'h7, 32'hffff_fe00, 2, 0, q); drain();

    // zero-length request with the response held off
    base = acks;
    hold_rdy_low = 1;
    q = {};
    issue_req($urandom, $urandom, 0, 0, q);
    for (int i = 0; i < 5; i++) begin
      chk("hold_resp_val", 32'(resp_val), 32'd1);
      chk("hold_req_rdy", 32'(req_rdy), 32'd0);
      @(negedge clk);
    end
    hold_rdy_low = 0;
    drain();
    chk("zero_cnt_no_bus", 32'(acks - base), 32'd0);

    for (int r = 0; r < 12; r++) begin
      cnt = $urandom_range(0, 4);
      q = {};
      for (int i = 0; i < cnt * (RETRIES + 1); i++)
        q.push_back(($urandom_range(0, 9) < 6) ? OC_OK : int'($urandom_range(1, 5)));
      issue_req($urandom, ($urandom_range(0, 3) == 0) ? 32'hffff_fc00 : $urandom, cnt, $urandom_range(0, 1), q);
      drain();
    end

    // reset during WAIT_CMD of the second block
    base = dma_writes;
    q = {OC_OK, OC_OK, OC_OK};
    issue_req(32'h200, 32'h4000, 3, 0, q);
    n = 0;
    while (!(dma_writes - base == 2 && state_o == ST_WAIT_CMD) && n < 2000) begin @(negedge clk); n++; end
    chk("reached_blk2_wait_cmd", 32'(state_o), 32'(ST_WAIT_CMD));
    rst = 1;
    #1;
    chk("abort_state", 32'(state_o), 32'(ST_IDLE));
    chk("abort_resp_val", 32'(resp_val), 32'd0);
    chk("abort_bus", 32'({wb_stb_o, wb_cyc_o, wb_we_o}), 32'd0);
    chk("abort_adr_dat", 32'(wb_adr_o) | wb_dat_o, 32'd0);
    chk("abort_resp_fields", 32'({resp_ok, resp_tmo, resp_done}), 32'd0);
    exp_wr_q.delete(); exp_rsp_q.delete(); outcome_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (resp_val) hi++; end
    chk("no_resp_after_abort", 32'(hi), 32'd0);
    chk("idle_after_abort", 32'(state_o), 32'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
